// File: rtl/caf_pkg.sv
// Shared CAF definitions: peak-finder FSM states, a clog2 helper and the
// elaboration-time legality check for the peak-finder parameter set.
package caf_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    HOLD   = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 1; k < v; k = k << 1) r++;
    return r;
  endfunction

  function automatic bit caf_params_ok(input int unsigned i_bits,
                                       input int unsigned q_bits,
                                       input int unsigned mag_bits,
                                       input int unsigned num_lags,
                                       input int unsigned lag_counter_size);
    return (q_bits == i_bits) && (mag_bits == 2 * i_bits) &&
           (num_lags >= 2) && (lag_counter_size >= clog2(num_lags));
  endfunction

endpackage

// File: rtl/cpx_mag_sq.sv
// Two-stage pipelined |i|^2 + |q|^2 with valid and tag passthrough.
module cpx_mag_sq #(
  parameter int i_bits   = 24,
  parameter int tag_bits = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic signed [i_bits-1:0]   i_i,
  input  logic signed [i_bits-1:0]   q_i,
  input  logic [tag_bits-1:0]        tag_i,
  output logic                       valid_o,
  output logic [2*i_bits-1:0]        mag_o,
  output logic [tag_bits-1:0]        tag_o
);

  localparam int PW = 2 * i_bits - 1;
  localparam int MW = 2 * i_bits;

  // A square is never negative, so the product's top bit is always zero
  // and the remaining PW bits hold it exactly (including (-2^(n-1))^2).
  logic [PW-1:0]       ii_d, qq_d;
  logic [PW-1:0]       ii_q, qq_q;
  logic                v1_q, v2_q;
  logic [tag_bits-1:0] tag1_q, tag2_q;
  logic [MW-1:0]       mag_d, mag_q;

  assign ii_d  = PW'(MW'(i_i) * MW'(i_i));
  assign qq_d  = PW'(MW'(q_i) * MW'(q_i));
  assign mag_d = MW'(ii_q) + MW'(qq_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ii_q   <= '0;
      qq_q   <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      mag_q  <= '0;
    end else begin
      v1_q   <= valid_i;
      ii_q   <= ii_d;
      qq_q   <= qq_d;
      tag1_q <= tag_i;
      v2_q   <= v1_q;
      mag_q  <= mag_d;
      tag2_q <= tag1_q;
    end
  end

  assign valid_o = v2_q;
  assign mag_o   = mag_q;
  assign tag_o   = tag2_q;

endmodule

// File: rtl/caf_peak_finder.sv
// Tracks the peak |i|^2+|q|^2 over a frame of num_lags correlation results
// and hands the peak magnitude and its lag downstream once per frame.
module caf_peak_finder
  import caf_pkg::*;
#(
  parameter int i_bits           = 24,
  parameter int q_bits           = 24,
  parameter int mag_bits         = 48,
  parameter int num_lags         = 16,
  parameter int lag_counter_size = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          m_axis_product_tvalid,
  input  logic signed [i_bits-1:0]      i,
  input  logic signed [q_bits-1:0]      q,
  output logic                          m_axis_product_tready,
  output logic                          s_axis_peak_tvalid,
  input  logic                          s_axis_peak_tready,
  output logic [mag_bits-1:0]           peak_mag,
  output logic [lag_counter_size-1:0]   peak_index
);

  if (!caf_params_ok(i_bits, q_bits, mag_bits, num_lags, lag_counter_size)) begin : g_param_check
    $error("caf_peak_finder: illegal parameter combination");
  end

  localparam int CW = lag_counter_size + 1;

  state_e                      state_q;
  logic [CW-1:0]               acc_cnt_q;
  logic [mag_bits-1:0]         run_max_q, peak_mag_q, max_d;
  logic [lag_counter_size-1:0] run_idx_q, peak_idx_q, idx_d;
  logic                        s_tvalid_q;
  logic                        accept, cmp_load, last_cmp;

  logic                        p2_valid;
  logic [2*i_bits-1:0]         p2_mag;
  logic [lag_counter_size-1:0] p2_tag;

  assign m_axis_product_tready = (state_q == SEARCH) && (acc_cnt_q < CW'(num_lags));
  assign accept                = m_axis_product_tvalid && m_axis_product_tready;

  cpx_mag_sq #(
    .i_bits   (i_bits),
    .tag_bits (lag_counter_size)
  ) u_mag_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (accept),
    .i_i     (i),
    .q_i     (q),
    .tag_i   (acc_cnt_q[lag_counter_size-1:0]),
    .valid_o (p2_valid),
    .mag_o   (p2_mag),
    .tag_o   (p2_tag)
  );

  // Lag 0 always loads so a frame of zeros still reports index 0.
  always_comb begin
    cmp_load = p2_valid && ((mag_bits'(p2_mag) > run_max_q) || (p2_tag == '0));
    max_d    = cmp_load ? mag_bits'(p2_mag) : run_max_q;
    idx_d    = cmp_load ? p2_tag : run_idx_q;
    last_cmp = p2_valid && (p2_tag == lag_counter_size'(num_lags - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      acc_cnt_q  <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      s_tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
          run_max_q <= max_d;
          run_idx_q <= idx_d;
          if (last_cmp) begin
            peak_mag_q <= max_d;
            peak_idx_q <= idx_d;
            s_tvalid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (s_axis_peak_tready) begin
            s_tvalid_q <= 1'b0;
            acc_cnt_q  <= '0;
            run_max_q  <= '0;
            state_q    <= SEARCH;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign s_axis_peak_tvalid = s_tvalid_q;
  assign peak_mag           = peak_mag_q;
  assign peak_index         = peak_idx_q;

endmodule

// File: tb/tb_caf_peak_finder.sv
// Randomized and directed bench for caf_peak_finder (num_lags=4) against a
// frame-level reference model of the peak search.
module tb_caf_peak_finder;

  localparam int NL  = 4;
  localparam int LCS = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               m_tvalid;
  logic signed [23:0] i_d, q_d;
  logic               m_tready;
  logic               s_tvalid;
  logic               s_tready;
  logic [47:0]        peak_mag;
  logic [LCS-1:0]     peak_index;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

  caf_peak_finder #(
    .i_bits           (24),
    .q_bits           (24),
    .mag_bits         (48),
    .num_lags         (NL),
    .lag_counter_size (LCS)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .m_axis_product_tvalid (m_tvalid),
    .i                     (i_d),
    .q                     (q_d),
    .m_axis_product_tready (m_tready),
    .s_axis_peak_tvalid    (s_tvalid),
    .s_axis_peak_tready    (s_tready),
    .peak_mag              (peak_mag),
    .peak_index            (peak_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint mag_of(input longint a, input longint b);
    return a * a + b * b;
  endfunction

  // Reference: largest magnitude in the frame, earliest lag on ties.
  task automatic ref_peak(input longint m[$], output longint pm, output int pi);
    pm = m[0];
    pi = 0;
    foreach (m[k]) if (m[k] > pm) begin pm = m[k]; pi = k; end
  endtask

  // Scoreboard state
  longint exp_mag_q[$];
  int     exp_idx_q[$];
  int     exp_cyc_q[$];
  longint fbuf[$];
  bit     in_hold = 0, post_hs = 0;
  longint cur_mag;
  int     cur_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      fbuf.delete(); exp_mag_q.delete(); exp_idx_q.delete(); exp_cyc_q.delete();
      in_hold = 0; post_hs = 0;
    end else begin
      if (post_hs) begin
        chk(!s_tvalid, "tvalid_drop_after_handshake", longint'(s_tvalid), 0);
        chk(m_tready, "upstream_ready_after_handshake", longint'(m_tready), 1);
        post_hs = 0;
      end
      if (m_tvalid && m_tready) begin
        fbuf.push_back(mag_of(longint'(i_d), longint'(q_d)));
        if (fbuf.size() == NL) begin
          longint pm; int pi;
          ref_peak(fbuf, pm, pi);
          exp_mag_q.push_back(pm); exp_idx_q.push_back(pi); exp_cyc_q.push_back(cyc + 3);
          fbuf.delete();
        end
      end
      if (s_tvalid) begin
        chk(!m_tready, "upstream_ready_low_in_hold", longint'(m_tready), 0);
        if (!in_hold) begin
          if (exp_mag_q.size() == 0) begin
            chk(0, "unexpected_peak", longint'(peak_mag), -1);
          end else begin
            int ec;
            cur_mag = exp_mag_q.pop_front(); cur_idx = exp_idx_q.pop_front(); ec = exp_cyc_q.pop_front();
            chk(longint'(peak_mag) == cur_mag, "peak_mag", longint'(peak_mag), cur_mag);
            chk(int'(peak_index) == cur_idx, "peak_index", longint'(peak_index), cur_idx);
            chk(cyc == ec, "peak_latency", cyc, ec);
          end
          in_hold = 1;
        end else begin
          chk(longint'(peak_mag) == cur_mag, "hold_mag_stable", longint'(peak_mag), cur_mag);
          chk(int'(peak_index) == cur_idx, "hold_index_stable", longint'(peak_index), cur_idx);
        end
        if (s_tready) begin in_hold = 0; post_hs = 1; end
      end else if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
        chk(0, "peak_late", cyc, exp_cyc_q[0]);
        void'(exp_mag_q.pop_front()); void'(exp_idx_q.pop_front()); void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    s_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: s_tready = 1'b1;
        1: s_tready = 1'b0;
        default: s_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input int a, input int b, input bit bub);
    bit acc;
    int budget;
    if (bub) while ($urandom_range(0, 2) == 0) begin m_tvalid = 1'b0; @(posedge clk); #1; end
    m_tvalid = 1'b1; i_d = 24'(a); q_d = 24'(b);
    acc = 0; budget = 0;
    while (!acc && budget < 60) begin
      @(negedge clk); acc = m_tready;
      @(posedge clk); #1;
      budget++;
    end
    if (!acc) chk(0, "upstream_ready_timeout", budget, 60);
    m_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int a[NL], input int b[NL], input bit bub);
    for (int k = 0; k < NL; k++) send(a[k], b[k], bub);
  endtask

  // Pins the reference model to a hand-computed result, then drives the frame.
  task automatic frame(input int a[NL], input int b[NL], input longint em, input int ei, input bit bub);
    longint m[$]; longint pm; int pi;
    for (int k = 0; k < NL; k++) m.push_back(mag_of(a[k], b[k]));
    ref_peak(m, pm, pi);
    chk(pm == em, "model_mag", pm, em);
    chk(pi == ei, "model_index", pi, ei);
    send_frame(a, b, bub);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_mag_q.size() != 0 || s_tvalid) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk(0, "idle_timeout", n, 200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a[NL], b[NL];
    int n;
    rst_n = 1'b0; m_tvalid = 1'b0; i_d = '0; q_d = '0;
    repeat (3) @(posedge clk); #1;
    chk(!s_tvalid, "reset_tvalid", longint'(s_tvalid), 0);
    chk(peak_mag == '0, "reset_mag", longint'(peak_mag), 0);
    chk(peak_index == '0, "reset_index", longint'(peak_index), 0);
    chk(m_tready, "reset_upstream_ready", longint'(m_tready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    frame('{1, 3, 0, -2}, '{0, 4, 2, -2}, 25, 1, 0);
    wait_idle();
    frame('{0, 3, -3, 0}, '{3, 0, 0, -3}, 9, 0, 0);
    wait_idle();
    frame('{0, 0, -8388608, 0}, '{0, 0, -8388608, 0}, 64'sd140737488355328, 2, 0);
    wait_idle();

    // Backpressure: downstream stalls for 10 cycles after the peak appears
    rdy_mode = 1;
    frame('{2, 0, 1, 2}, '{1, 0, 2, 1}, 5, 0, 0);
    n = 0;
    while (!s_tvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk(s_tvalid, "stall_peak_seen", longint'(s_tvalid), 1);
    repeat (10) @(posedge clk);
    #1 rdy_mode = 0;
    frame('{5, 5, 5, 5}, '{0, 0, 0, 0}, 25, 0, 0);
    wait_idle();

    // Asynchronous reset after two accepts of a frame
    send(0, 1, 0);
    send(0, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk(!s_tvalid, "midreset_tvalid", longint'(s_tvalid), 0);
    chk(peak_mag == '0, "midreset_mag", longint'(peak_mag), 0);
    chk(peak_index == '0, "midreset_index", longint'(peak_index), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    frame('{0, 0, 0, 0}, '{1, 1, 7, 1}, 49, 2, 0);
    wait_idle();

    // Bubbles on upstream valid
    frame('{1, 3, 0, -2}, '{0, 4, 2, -2}, 25, 1, 1);
    wait_idle();

    // Randomized frames: wide and small-range data, bubbles, random downstream ready
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < NL; k++) begin
        if (f % 2 == 0) begin
          a[k] = int'($urandom_range(0, 6)) - 3;
          b[k] = int'($urandom_range(0, 6)) - 3;
        end else begin
          a[k] = int'({{8{1'b0}}, 24'($urandom)}) - 8388608;
          b[k] = int'({{8{1'b0}}, 24'($urandom)}) - 8388608;
        end
      end
      send_frame(a, b, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
